writeback_regfile: RTL
======================

Name: writeback_regfile

Overview:
- Write-back stage directly downstream of the MEM/WB pipeline register.
- Selects the write-back value from the MEM/WB outputs and commits it to a 32x32 general-purpose register file.
- Provides two decode-stage read ports with same-cycle write-through bypass, plus a registered debug/display port and a write-commit counter for the motion-estimation (SAD) board display.

Parameters:
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
- DW, 32, data width.
- PC_LINK_OFFSET, 4, added to PCin for link write-back (MemToRegIn = 2'b10).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- RegWriteIn  in  1  write enable from MEM/WB.
- MemToRegIn  in  2  write-back source: 00 ALU result, 01 memory read data, 10 PCin+PC_LINK_OFFSET, 11 no write.
- RDin  in  32  memory read data from MEM/WB.
- ALUResultIn  in  32  ALU result from MEM/WB.
- PCin  in  32  PC from MEM/WB.
- WriteRegisterIn  in  5  destination register index.
- ReadRegister1  in  5  read port 1 index (decode stage).
- ReadRegister2  in  5  read port 2 index (decode stage).
- ReadData1  out  32  read port 1 data, combinational.
- ReadData2  out  32  read port 2 data, combinational.
- WriteDataOut  out  32  selected write-back value, combinational; feeds EX forwarding.
- WriteEnEff  out  1  effective write strobe, combinational.
- DispSel  in  5  register index to display.
- DispData  out  32  registered snapshot of register DispSel.
- WriteCount  out  32  number of committed register writes.
- LastWritePC  out  32  PCin of the most recent committed write.

Behaviour:
- WriteDataOut mux by MemToRegIn:
  - 00: ALUResultIn.
  - 01: RDin.
  - 10: PCin + PC_LINK_OFFSET, mod 2^32 (carry dropped).
  - 11: 0.
- WriteEnEff = RegWriteIn AND (MemToRegIn != 2'b11) AND (WriteRegisterIn != 0) AND NOT Reset.
- Commit: on posedge Clk with WriteEnEff = 1, regs[WriteRegisterIn] <= WriteDataOut. Latency 1 cycle; the value is visible in the array on the next cycle.
- Register $0:
  - Never written; reads always return 0, including through the bypass.
  - A write to $0 does not count and does not update LastWritePC.
- Read ports:
  - ReadDataX = 0 if ReadRegisterX = 0.
  - Else ReadDataX = WriteDataOut if WriteEnEff = 1 and WriteRegisterIn = ReadRegisterX (write-through bypass).
  - Else ReadDataX = regs[ReadRegisterX].
  - Both ports may hit the bypass at once.
- DispData: posedge register of the same read function applied to DispSel, bypass included. Latency 1 cycle.
- WriteCount: +1 on each commit; saturates at 32'hFFFF_FFFF (no wrap).
- LastWritePC <= PCin on each commit.
- Reset (synchronous) clears:
  - All 32 registers.
  - DispData, WriteCount and LastWritePC, all to 0.
- Reset priority:
  - Reset wins over a simultaneous commit; that write is dropped.
  - Bypass is disabled while Reset = 1, so reads return 0.
- Reset mid-stream: the pipeline may still present a valid MEM/WB word during Reset; it is discarded, not deferred.
- No X propagation: before the first reset, register contents are don't-care; the verification bench must reset first.

Test Plan:
- Reset 1 cycle, then read all 32 indices -> every ReadData1/2 = 0, WriteCount = 0, DispData = 0 one cycle after DispSel is set.
- RegWriteIn = 1, MemToRegIn = 00, ALUResultIn = 32'h1234_5678, WriteRegisterIn = 5, ReadRegister1 = 5 in the same cycle -> ReadData1 = 32'h1234_5678 via bypass. Next cycle, with RegWriteIn = 0 -> still 32'h1234_5678. WriteCount = 1, LastWritePC = PCin.
- Source select:
  - MemToRegIn = 01, RDin = 32'hDEAD_BEEF -> r7.
  - MemToRegIn = 10, PCin = 32'hFFFF_FFFC -> r31 = 32'h0000_0000 (wrap).
  - MemToRegIn = 11 with RegWriteIn = 1 -> no write, WriteEnEff = 0, count unchanged.
- Write 32'hAAAA_AAAA to $0 -> ReadData1/2 for index 0 = 0 in the same cycle and all later cycles; WriteCount unchanged.
- Reset asserted in the same cycle as a commit to r3 = 32'h55 -> the next cycle r3 = 0, WriteCount = 0, LastWritePC = 0.
- Preload WriteCount to 32'hFFFF_FFFE (via force or long run), then perform 3 commits -> WriteCount = 32'hFFFF_FFFF, no wrap. DispSel = 3 with a same-cycle write of 32'h77 to r3 -> DispData = 32'h77 on the next edge.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-regfile bundle: write-back inputs, decode read ports, display and commit status.
// Clock and reset stay outside the bundle.
interface writeback_regfile_if #(
    parameter int NREG = 32,
    parameter int DW   = 32
);
    localparam int AW = $clog2(NREG);

    logic          RegWriteIn;
    logic [1:0]    MemToRegIn;
    logic [DW-1:0] RDin;
    logic [DW-1:0] ALUResultIn;
    logic [DW-1:0] PCin;
    logic [AW-1:0] WriteRegisterIn;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic [DW-1:0] WriteDataOut;
    logic          WriteEnEff;
    logic [AW-1:0] DispSel;
    logic [DW-1:0] DispData;
    logic [31:0]   WriteCount;
    logic [DW-1:0] LastWritePC;

    modport master (
        output RegWriteIn, MemToRegIn, RDin, ALUResultIn, PCin, WriteRegisterIn,
               ReadRegister1, ReadRegister2, DispSel,
        input  ReadData1, ReadData2, WriteDataOut, WriteEnEff, DispData,
               WriteCount, LastWritePC
    );

    modport slave (
        input  RegWriteIn, MemToRegIn, RDin, ALUResultIn, PCin, WriteRegisterIn,
               ReadRegister1, ReadRegister2, DispSel,
        output ReadData1, ReadData2, WriteDataOut, WriteEnEff, DispData,
               WriteCount, LastWritePC
    );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back select + 32x32 regfile with write-through read ports; commit latency 1 cycle.
// No backpressure: each MEM/WB word is committed or dropped in the cycle it is presented.
module writeback_regfile #(
    parameter int NREG           = 32,
    parameter int DW             = 32,
    parameter int PC_LINK_OFFSET = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    writeback_regfile_if.slave   wb
);
    localparam int AW = $clog2(NREG);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] disp_q, disp_d;
    logic [31:0]   write_count_q, write_count_d;
    logic [DW-1:0] last_pc_q;
    logic [DW-1:0] wr_data;
    logic          wr_en;

    always_comb begin
        wr_data = '0;
        case (wb.MemToRegIn)
            2'b00:   wr_data = wb.ALUResultIn;
            2'b01:   wr_data = wb.RDin;
            2'b10:   wr_data = wb.PCin + DW'(PC_LINK_OFFSET);
            default: wr_data = '0;
        endcase
    end

    assign wr_en = wb.RegWriteIn && (wb.MemToRegIn != 2'b11) &&
                   (wb.WriteRegisterIn != '0) && !Reset;

    // $0 and reset force zero; otherwise a same-cycle commit to idx wins over the array.
    function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] idx);
        if (Reset || idx == '0)
            return '0;
        if (wr_en && wb.WriteRegisterIn == idx)
            return wr_data;
        return regs_q[idx];
    endfunction

    assign disp_d        = read_reg(wb.DispSel);
    assign write_count_d = (write_count_q == 32'hFFFF_FFFF) ? write_count_q
                                                            : write_count_q + 32'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wb.WriteRegisterIn] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            disp_q        <= '0;
            write_count_q <= '0;
            last_pc_q     <= '0;
        end else begin
            disp_q <= disp_d;
            if (wr_en) begin
                write_count_q <= write_count_d;
                last_pc_q     <= wb.PCin;
            end
        end
    end

    assign wb.ReadData1    = read_reg(wb.ReadRegister1);
    assign wb.ReadData2    = read_reg(wb.ReadRegister2);
    assign wb.WriteDataOut = wr_data;
    assign wb.WriteEnEff   = wr_en;
    assign wb.DispData     = disp_q;
    assign wb.WriteCount   = write_count_q;
    assign wb.LastWritePC  = last_pc_q;
endmodule
